// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request channel: fixed
// request-to-response latency, one-cycle response strobe, fault on bad address.
module dmem_responder #(
  parameter int AW  = 6,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_we_q;
  logic          op_err_q;
  logic [AW-1:0] op_idx_q;
  logic [31:0]   op_wdata_q;
  logic [31:0]   mem_q [2**AW];
  logic [31:0]   rdata_q;

  logic          accept;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          cur_we;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic          commit;

  assign req_ready = (state_q != WAIT);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[AW+1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

  // With LAT=1 the accept edge is also the edge entering RESP, so the memory
  // access has to use the live request rather than the captured copy.
  generate
    if (LAT == 1) begin : g_direct
      assign cur_we    = req_we;
      assign cur_err   = req_err;
      assign cur_idx   = req_idx;
      assign cur_wdata = req_wdata;
    end else begin : g_captured
      assign cur_we    = op_we_q;
      assign cur_err   = op_err_q;
      assign cur_idx   = op_idx_q;
      assign cur_wdata = op_wdata_q;
    end
  endgenerate

  assign commit = reset && (state_d == RESP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LAT == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
        if (state_q == RESP) begin
          rsp_valid = 1'b1;
          rsp_err   = op_err_q;
          rsp_rdata = (op_err_q || op_we_q) ? 32'd0 : rdata_q;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_we_q    <= 1'b0;
      op_err_q   <= 1'b0;
      op_idx_q   <= '0;
      op_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_we_q    <= req_we;
        op_err_q   <= req_err;
        op_idx_q   <= req_idx;
        op_wdata_q <= req_wdata;
      end
    end
  end

  // Array contents survive reset; the access happens on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (commit && !cur_err) begin
      if (cur_we) begin
        mem_q[cur_idx] <= cur_wdata;
      end else begin
        rdata_q <= mem_q[cur_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with LAT=1..4 checked against a
// per-instance word-array model and the latency/handshake rules.
module tb_dmem_responder;

  localparam int N     = 4;
  localparam int AW    = 6;
  localparam int WORDS = 64;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_we;
  logic [31:0]      req_addr  [N];
  logic [31:0]      req_wdata [N];
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_rdata [N];
  logic [N-1:0]     rsp_err;
  logic [N-1:0]     busy;

  logic [31:0]      mem_m [N][WORDS];
  int               checks = 0;
  int               errors = 0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      dmem_responder #(.AW(AW), .LAT(gi + 1)) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  function automatic logic [31:0] word_addr(input int idx);
    return 32'(idx) << 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on an idle instance: accept, then the strobe
  // must appear at the LAT-th edge after acceptance and nowhere else.
  task automatic xact(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int            lat;
    int            waited;
    logic          exp_err;
    logic [31:0]   exp_rd;
    logic [AW-1:0] idx;
    lat = i + 1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_valid[i] = 1'b1;
    waited = 0;
    while (req_ready[i] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (req_ready[i] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout inst%0d: req_ready=%b required 1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      return;
    end
    exp_err = is_fault(addr);
    idx     = addr[AW+1:2];
    exp_rd  = 32'd0;
    if (!exp_err) begin
      if (we) mem_m[i][idx] = wdata;
      else    exp_rd = mem_m[i][idx];
    end
    tick();
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom_range(0, 1));
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    for (int s = 0; s < lat; s++) begin
      if (s > 0) tick();
      checks++;
      if (rsp_valid[i] !== (s == lat - 1)) begin
        errors++;
        $display("FAIL rsp_timing inst%0d step%0d: rsp_valid=%b required %b",
                 i, s, rsp_valid[i], (s == lat - 1));
      end
      checks++;
      if (busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL busy_inflight inst%0d step%0d: busy=%b required 1", i, s, busy[i]);
      end
      if (s == lat - 1) begin
        checks++;
        if (rsp_err[i] !== exp_err) begin
          errors++;
          $display("FAIL rsp_err inst%0d addr=%h: rsp_err=%b required %b",
                   i, addr, rsp_err[i], exp_err);
        end
        checks++;
        if (rsp_rdata[i] !== exp_rd) begin
          errors++;
          $display("FAIL rsp_rdata inst%0d addr=%h we=%b: rsp_rdata=%h required %h",
                   i, addr, we, rsp_rdata[i], exp_rd);
        end
      end else begin
        checks++;
        if (rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0) begin
          errors++;
          $display("FAIL rsp_quiet inst%0d step%0d: rdata=%h err=%b required 0/0",
                   i, s, rsp_rdata[i], rsp_err[i]);
        end
      end
    end
    tick();
    checks++;
    if (rsp_valid[i] !== 1'b0 || busy[i] !== 1'b0 || rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after inst%0d: valid=%b busy=%b rdata=%h err=%b required all 0",
               i, rsp_valid[i], busy[i], rsp_rdata[i], rsp_err[i]);
    end
    $display("xact inst%0d lat=%0d we=%b addr=%h wdata=%h exp_rdata=%h exp_err=%b",
             i, lat, we, addr, wdata, exp_rd, exp_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0 ||
          busy[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: valid=%b rdata=%h err=%b busy=%b ready=%b required 0/0/0/0/1",
                 i, rsp_valid[i], rsp_rdata[i], rsp_err[i], busy[i], req_ready[i]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL ready_after_reset inst%0d: ready=%b busy=%b required 1/0",
                 i, req_ready[i], busy[i]);
      end
    end
    $display("reset released");
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < WORDS; w++) begin
        xact(i, 1'b1, word_addr(w), $urandom);
      end
    end
  endtask

  task automatic test_store_load();
    xact(1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    xact(1, 1'b0, 32'h0000_0008, 32'h0);
    checks++;
    if (mem_m[1][2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL model_word2: model=%h required deadbeef", mem_m[1][2]);
    end
    for (int i = 0; i < N; i++) begin
      int w;
      w = $urandom_range(0, WORDS - 1);
      xact(i, 1'b1, word_addr(w), $urandom);
      xact(i, 1'b0, word_addr(w), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = 32'h1234_5678;
    req_we[1] = 1'b1; req_addr[1] = 32'h10; req_wdata[1] = d; req_valid[1] = 1'b1;
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_idle: req_ready=%b required 1", req_ready[1]);
    end
    tick();
    req_we[1] = 1'b0; req_wdata[1] = $urandom;
    checks++;
    if (req_ready[1] !== 1'b0 || busy[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait: ready=%b busy=%b valid=%b required 0/1/0",
               req_ready[1], busy[1], rsp_valid[1]);
    end
    tick();
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_err[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 ||
        req_ready[1] !== 1'b1 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_store_rsp: valid=%b err=%b rdata=%h ready=%b busy=%b required 1/0/0/1/1",
               rsp_valid[1], rsp_err[1], rsp_rdata[1], req_ready[1], busy[1]);
    end
    tick();
    req_valid[1] = 1'b0;
    checks++;
    if (rsp_valid[1] !== 1'b0 || busy[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load_wait: valid=%b busy=%b ready=%b required 0/1/0",
               rsp_valid[1], busy[1], req_ready[1]);
    end
    tick();
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== d || rsp_err[1] !== 1'b0 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load_rsp: valid=%b rdata=%h err=%b busy=%b required 1/%h/0/1",
               rsp_valid[1], rsp_rdata[1], rsp_err[1], busy[1], d);
    end
    mem_m[1][4] = d;
    tick();
    checks++;
    if (busy[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b valid=%b required 0/0", busy[1], rsp_valid[1]);
    end
    $display("xact inst1 back-to-back store/load addr=00000010 data=%h", d);
  endtask

  task automatic test_faults();
    xact(1, 1'b1, 32'h0000_0006, $urandom);
    xact(1, 1'b1, 32'h0000_0400, $urandom);
    xact(1, 1'b0, 32'h0000_0004, 32'h0);
    xact(1, 1'b0, 32'h0000_0000, 32'h0);
    for (int i = 0; i < N; i++) begin
      xact(i, 1'b0, word_addr($urandom_range(0, WORDS - 1)) | 32'($urandom_range(1, 3)), 32'h0);
      xact(i, 1'b1, 32'h8000_0000 | word_addr($urandom_range(0, WORDS - 1)), $urandom);
    end
  endtask

  task automatic test_lat1_stream();
    int idx [3];
    for (int k = 0; k < 3; k++) idx[k] = $urandom_range(0, WORDS - 1);
    req_we[0] = 1'b0; req_addr[0] = word_addr(idx[0]); req_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL lat1_ready k%0d: req_ready=%b required 1", k, req_ready[0]);
      end
      tick();
      if (k < 2) req_addr[0] = word_addr(idx[k+1]);
      else       req_valid[0] = 1'b0;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== mem_m[0][idx[k]] || rsp_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL lat1_rsp k%0d: valid=%b rdata=%h err=%b required 1/%h/0",
                 k, rsp_valid[0], rsp_rdata[0], rsp_err[0], mem_m[0][idx[k]]);
      end
      $display("xact inst0 stream load word=%0d exp_rdata=%h", idx[k], mem_m[0][idx[k]]);
    end
    tick();
    checks++;
    if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle: valid=%b busy=%b required 0/0", rsp_valid[0], busy[0]);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] old;
    old = mem_m[2][8];
    req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'hA5A5_A5A5; req_valid[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    tick();
    checks++;
    if (busy[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL inflight_busy: busy=%b valid=%b required 1/0", busy[2], rsp_valid[2]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy[2] !== 1'b0 || rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 32'd0 ||
        rsp_err[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_wait: busy=%b valid=%b rdata=%h err=%b ready=%b required 0/0/0/0/1",
               busy[2], rsp_valid[2], rsp_rdata[2], rsp_err[2], req_ready[2]);
    end
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (rsp_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
        errors++;
        $display("FAIL discarded_request step%0d: valid=%b busy=%b required 0/0",
                 s, rsp_valid[2], busy[2]);
      end
    end
    xact(2, 1'b0, 32'h20, 32'h0);
    checks++;
    if (mem_m[2][8] !== old) begin
      errors++;
      $display("FAIL model_preserved: model=%h required %h", mem_m[2][8], old);
    end
    // Reset during a load response must zero the strobe and data at once.
    req_we[1] = 1'b0; req_addr[1] = word_addr(5); req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    tick();
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== mem_m[1][5]) begin
      errors++;
      $display("FAIL resp_before_reset: valid=%b rdata=%h required 1/%h",
               rsp_valid[1], rsp_rdata[1], mem_m[1][5]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 || rsp_err[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_resp: valid=%b rdata=%h err=%b busy=%b required 0/0/0/0",
               rsp_valid[1], rsp_rdata[1], rsp_err[1], busy[1]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    $display("xact reset-in-flight scenarios done");
  endtask

  task automatic test_wait_block();
    int          ia;
    int          ib;
    logic        exp_v;
    logic [31:0] exp_d;
    ia = $urandom_range(0, WORDS - 1);
    ib = $urandom_range(0, WORDS - 1);
    req_we[3] = 1'b0; req_addr[3] = word_addr(ia); req_valid[3] = 1'b1;
    tick();
    req_addr[3] = word_addr(ib);
    for (int s = 0; s < 8; s++) begin
      if (s > 0) tick();
      if (s == 4) req_valid[3] = 1'b0;
      exp_v = (s == 3) || (s == 7);
      exp_d = (s == 3) ? mem_m[3][ia] : ((s == 7) ? mem_m[3][ib] : 32'd0);
      checks++;
      if (req_ready[3] !== exp_v || rsp_valid[3] !== exp_v || rsp_rdata[3] !== exp_d) begin
        errors++;
        $display("FAIL wait_block step%0d: ready=%b valid=%b rdata=%h required %b/%b/%h",
                 s, req_ready[3], rsp_valid[3], rsp_rdata[3], exp_v, exp_v, exp_d);
      end
    end
    tick();
    checks++;
    if (busy[3] !== 1'b0 || rsp_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL wait_block_idle: busy=%b valid=%b required 0/0", busy[3], rsp_valid[3]);
    end
    $display("xact inst3 loads word=%0d word=%0d with valid held through WAIT", ia, ib);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          k;
    for (int i = 0; i < N; i++) begin
      for (int n = 0; n < 40; n++) begin
        k = $urandom_range(0, 9);
        a = word_addr($urandom_range(0, WORDS - 1));
        if (k == 0) begin
          a = a | 32'($urandom_range(1, 3));
        end else if (k == 1) begin
          a = $urandom;
          if (a[31:AW+2] == '0) a[AW+2] = 1'b1;
        end
        xact(i, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_back_to_back();
    test_faults();
    test_lat1_stream();
    test_reset_inflight();
    test_wait_block();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
